// File: rtl/pll_reset_seq_pkg.sv
// pll_reset_seq_pkg: state encoding, default timing constants and counter sizing for pll_reset_seq
package pll_reset_seq_pkg;
  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, HOLD, RUN, FAIL} state_e;
  localparam int DEF_PLL_RST_CYC  = 16;
  localparam int DEF_LOCK_TIMEOUT = 500000;
  localparam int DEF_HOLD_CYC     = 1024;
  localparam int DEF_FILT_CYC     = 4;
  localparam int DEF_MAX_RETRY    = 7;
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/pll_reset_seq_sync_filter.sv
// sync_filter: 2-flop synchronizer plus a FILT_CYC-sample consistency filter (FILT_CYC=1 is synchronizer only)
module sync_filter #(
  parameter int FILT_CYC = 4
) (
  input  logic clk_50,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], d_i};
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else sync_q <= sync_d;
  end
  if (FILT_CYC <= 1) begin : g_pass
    assign q_o = sync_q[1];
  end else begin : g_filt
    localparam int FW = $clog2(FILT_CYC);
    logic [FW-1:0] cnt_q, cnt_d;
    logic filt_q, filt_d;
    // the output flips on the FILT_CYC-th consecutive sample that disagrees with it
    always_comb begin
      filt_d = filt_q;
      cnt_d = '0;
      if (sync_q[1] != filt_q) begin
        if (cnt_q == FW'(FILT_CYC - 1)) filt_d = sync_q[1];
        else cnt_d = cnt_q + 1'b1;
      end
    end
    always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        filt_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        filt_q <= filt_d;
      end
    end
    assign q_o = filt_q;
  end
endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: PLL reset pulse, lock wait with timeout, core-reset hold; PLLSEQ_RETRY_EN enables timeout retries
module pll_reset_seq
  import pll_reset_seq_pkg::*;
#(
  parameter int PLL_RST_CYC  = DEF_PLL_RST_CYC,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int FILT_CYC     = DEF_FILT_CYC,
  parameter int MAX_RETRY    = DEF_MAX_RETRY
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       user_reset,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_cnt
);
  localparam int CW = cnt_w(PLL_RST_CYC, LOCK_TIMEOUT, HOLD_CYC);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic init_q, lk_f, ur_s, expired;
  logic pll_rst_q, pll_rst_d, core_reset_q, core_reset_d, ready_q, ready_d, fail_q, fail_d;
`ifdef PLLSEQ_RETRY_EN
  logic [2:0] retry_q, retry_d;
`endif
  sync_filter #(.FILT_CYC(FILT_CYC)) u_lk (.clk_50(clk_50), .rst_n(rst_n), .d_i(pll_locked), .q_o(lk_f));
  sync_filter #(.FILT_CYC(1)) u_ur (.clk_50(clk_50), .rst_n(rst_n), .d_i(user_reset), .q_o(ur_s));
  assign expired = cnt_q == '0;
  // the first cycle after rst_n already counts toward the reset pulse, so it loads one less
  always_comb begin
    state_d = state_q;
    cnt_d = expired ? '0 : cnt_q - 1'b1;
`ifdef PLLSEQ_RETRY_EN
    retry_d = retry_q;
`endif
    if (ur_s && state_q != FAIL) begin
      state_d = PLL_RST;
      cnt_d = CW'(PLL_RST_CYC - 1);
    end else if (init_q) begin
      cnt_d = CW'(PLL_RST_CYC - 2);
    end else begin
      case (state_q)
        PLL_RST: if (expired) begin
          state_d = WAIT_LOCK;
          cnt_d = CW'(LOCK_TIMEOUT - 1);
        end
        WAIT_LOCK: if (lk_f) begin
          state_d = HOLD;
          cnt_d = CW'(HOLD_CYC - 1);
        end
`ifdef PLLSEQ_RETRY_EN
        else if (expired && retry_q < 3'(MAX_RETRY)) begin
          state_d = PLL_RST;
          cnt_d = CW'(PLL_RST_CYC - 1);
          retry_d = retry_q + 1'b1;
        end
`endif
        else if (expired) state_d = FAIL;
        HOLD: if (!lk_f) begin
          state_d = WAIT_LOCK;
          cnt_d = CW'(LOCK_TIMEOUT - 1);
        end else if (expired) state_d = RUN;
        RUN: if (!lk_f) begin
          state_d = WAIT_LOCK;
          cnt_d = CW'(LOCK_TIMEOUT - 1);
        end
        default: ;
      endcase
    end
    pll_rst_d = state_d == PLL_RST;
    core_reset_d = state_d != RUN;
    ready_d = state_d == RUN;
    fail_d = state_d == FAIL;
  end
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PLL_RST;
      cnt_q <= '0;
      init_q <= 1'b1;
      pll_rst_q <= 1'b1;
      core_reset_q <= 1'b1;
      ready_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      init_q <= 1'b0;
      pll_rst_q <= pll_rst_d;
      core_reset_q <= core_reset_d;
      ready_q <= ready_d;
      fail_q <= fail_d;
    end
  end
`ifdef PLLSEQ_RETRY_EN
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) retry_q <= '0;
    else retry_q <= retry_d;
  end
  assign retry_cnt = retry_q;
`else
  assign retry_cnt = '0;
`endif
  assign pll_rst = pll_rst_q;
  assign core_reset = core_reset_q;
  assign ready = ready_q;
  assign fail = fail_q;
endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: stimulus queues the expected output changes; a negedge monitor pops and compares each change
`timescale 1ns/1ps
module tb_pll_reset_seq;
  typedef struct {
    logic [6:0] v;
    int         lo;
    int         hi;
    string      name;
  } exp_t;
  logic clk_50 = 1'b0, rst_n = 1'b0, pll_locked = 1'b0, user_reset = 1'b0;
  logic pll_rst, core_reset, ready, fail;
  logic [2:0] retry_cnt;
  logic [6:0] o;
  logic [6:0] prev = 7'b1100000;
  int cyc = 0, checks = 0, errors = 0;
  exp_t sb[$];

  pll_reset_seq #(.LOCK_TIMEOUT(100)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .pll_locked(pll_locked), .user_reset(user_reset),
    .pll_rst(pll_rst), .core_reset(core_reset), .ready(ready), .fail(fail), .retry_cnt(retry_cnt)
  );

  always #5 clk_50 = ~clk_50;
  always @(posedge clk_50) cyc <= cyc + 1;
  assign o = {pll_rst, core_reset, ready, fail, retry_cnt};

  task automatic expect_at(input string n, input logic [6:0] v, input int lo, input int hi);
    exp_t e;
    e.v = v; e.lo = lo; e.hi = hi; e.name = n;
    sb.push_back(e);
  endtask

  task automatic chk(input string n, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", n, got, req);
    end
  endtask

  // output vector is {pll_rst, core_reset, ready, fail, retry_cnt}
  always @(negedge clk_50) begin
    exp_t e;
    if (cyc >= 2 && o !== prev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got %b at cycle %0d, required %b unchanged", o, cyc, prev);
      end else begin
        e = sb.pop_front();
        if (o !== e.v || cyc < e.lo || cyc > e.hi) begin
          errors++;
          $display("FAIL %s: got %b at cycle %0d, required %b in cycles %0d..%0d", e.name, o, cyc, e.v, e.lo, e.hi);
        end
      end
      prev = o;
    end
  end

  initial begin
    int r, l, g, h;
    repeat (3) @(negedge clk_50);
    chk("reset_values", o, 7'b1100000);
    rst_n = 1'b1;
    r = cyc;
    expect_at("bringup_pll_rst_fall", 7'b0100000, r + 16, r + 16);
    repeat (40) @(negedge clk_50);
    pll_locked = 1'b1;
    l = cyc;
    expect_at("bringup_run", 7'b0010000, l + 1030, l + 1031);
    repeat (1100) @(negedge clk_50);
    chk("bringup_ready", ready, 1);
    pll_locked = 1'b0;
    repeat (3) @(negedge clk_50);
    pll_locked = 1'b1;
    repeat (20) @(negedge clk_50);
    chk("glitch3_ready", ready, 1);
    g = cyc;
    pll_locked = 1'b0;
    expect_at("glitch6_core_reset", 7'b0100000, g + 7, g + 7);
    repeat (6) @(negedge clk_50);
    pll_locked = 1'b1;
    l = cyc;
    expect_at("relock_run", 7'b0010000, l + 1030, l + 1031);
    repeat (1100) @(negedge clk_50);
    h = cyc;
    user_reset = 1'b1;
    expect_at("ur_run_pll_rst", 7'b1100000, h + 3, h + 3);
    expect_at("ur_run_pulse_end", 7'b0100000, h + 19, h + 19);
    @(negedge clk_50);
    user_reset = 1'b0;
    repeat (70) @(negedge clk_50);
    h = cyc;
    user_reset = 1'b1;
    expect_at("ur_hold_pll_rst", 7'b1100000, h + 3, h + 3);
    expect_at("ur_hold_pulse_end", 7'b0100000, h + 19, h + 19);
    expect_at("ur_hold_run", 7'b0010000, h + 1044, h + 1044);
    @(negedge clk_50);
    user_reset = 1'b0;
    repeat (1100) @(negedge clk_50);
    chk("retry_unchanged", retry_cnt, 0);
    g = cyc;
    pll_locked = 1'b0;
    expect_at("lock_loss", 7'b0100000, g + 7, g + 7);
    repeat (30) @(negedge clk_50);
    #2 rst_n = 1'b0;
    g = cyc;
    expect_at("async_rst", 7'b1100000, g, g + 1);
    #1 chk("async_rst_immediate", o, 7'b1100000);
    repeat (3) @(negedge clk_50);
    rst_n = 1'b1;
    r = cyc;
    expect_at("timeout_pll_rst_fall", 7'b0100000, r + 16, r + 16);
`ifdef PLLSEQ_RETRY_EN
    for (int k = 1; k <= 7; k++) begin
      expect_at("retry_pulse", {4'b1100, 3'(k)}, r + 116 * k, r + 116 * k);
      expect_at("retry_wait", {4'b0100, 3'(k)}, r + 116 * k + 16, r + 116 * k + 16);
    end
    expect_at("retry_exhausted", 7'b0101111, r + 928, r + 928);
    repeat (960) @(negedge clk_50);
`else
    expect_at("timeout_to_fail", 7'b0101000, r + 116, r + 116);
    repeat (150) @(negedge clk_50);
`endif
    user_reset = 1'b1;
    @(negedge clk_50);
    user_reset = 1'b0;
    pll_locked = 1'b1;
    repeat (30) @(negedge clk_50);
    #1 chk("fail_sticky", fail, 1);
    chk("fail_pll_rst_low", pll_rst, 0);
    #1 rst_n = 1'b0;
    g = cyc;
    expect_at("async_rst_clears_fail", 7'b1100000, g, g + 1);
    #1 chk("async_rst_clear", o, 7'b1100000);
    repeat (3) @(negedge clk_50);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
